// File: rtl/pipelined_segment_adder.sv
// Segmented-carry pipelined adder: one register stage per SEG-bit slice, valid/ready on both sides.
// Optional signed-overflow output is enabled by defining PSA_OVF_EN.
module pipelined_segment_adder #(
    parameter int WIDTH = 16,
    parameter int SEG   = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_a,
    input  logic [WIDTH-1:0] in_b,
    input  logic             in_cin,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_sum,
    output logic             out_cout,
    output logic             out_ovf
);

    localparam int STAGES = WIDTH / SEG;

    function automatic logic [SEG:0] seg_add(input logic [SEG-1:0] a,
                                             input logic [SEG-1:0] b,
                                             input logic           cin);
        logic [SEG:0] r;
        logic         c;
        r = {(SEG+1){1'b0}};
        c = cin;
        for (int i = 0; i < SEG; i++) begin
            r[i] = a[i] ^ b[i] ^ c;
            c    = (a[i] & b[i]) | (c & (a[i] ^ b[i]));
        end
        r[SEG] = c;
        return r;
    endfunction

    logic [STAGES-1:0] v_q;
    logic [STAGES-1:0] v_d;
    logic [STAGES-1:0] load_s;
    logic [WIDTH-1:0]  sum_q   [STAGES];
    logic [WIDTH-1:0]  sum_d   [STAGES];
    logic [WIDTH-1:0]  rem_a_q [STAGES];
    logic [WIDTH-1:0]  rem_a_d [STAGES];
    logic [WIDTH-1:0]  rem_b_q [STAGES];
    logic [WIDTH-1:0]  rem_b_d [STAGES];
    logic              cy_q    [STAGES];
    logic              cy_d    [STAGES];
    logic [WIDTH-1:0]  src_a_s   [STAGES];
    logic [WIDTH-1:0]  src_b_s   [STAGES];
    logic [WIDTH-1:0]  src_sum_s [STAGES];
    logic              src_c_s   [STAGES];
    logic [SEG:0]      seg_s     [STAGES];

    // Handshake: a stage may load when it is empty or anything downstream frees up this cycle.
    always_comb begin
        logic free;
        free = out_ready;
        for (int k = STAGES - 1; k >= 0; k--) begin
            free      = free | ~v_q[k];
            load_s[k] = free;
        end
        v_d[0] = load_s[0] ? in_valid : v_q[0];
        for (int k = 1; k < STAGES; k++) begin
            v_d[k] = load_s[k] ? v_q[k-1] : v_q[k];
        end
    end

    assign in_ready = load_s[0];

    // Datapath: each stage adds its slice; operands are shifted down so the next slice sits at bit 0.
    always_comb begin
        src_a_s[0]   = in_a;
        src_b_s[0]   = in_b;
        src_c_s[0]   = in_cin;
        src_sum_s[0] = {WIDTH{1'b0}};
        for (int k = 1; k < STAGES; k++) begin
            src_a_s[k]   = rem_a_q[k-1];
            src_b_s[k]   = rem_b_q[k-1];
            src_c_s[k]   = cy_q[k-1];
            src_sum_s[k] = sum_q[k-1];
        end
        for (int k = 0; k < STAGES; k++) begin
            seg_s[k] = seg_add(src_a_s[k][SEG-1:0], src_b_s[k][SEG-1:0], src_c_s[k]);
            if (load_s[k]) begin
                sum_d[k]                = src_sum_s[k];
                sum_d[k][k*SEG +: SEG]  = seg_s[k][SEG-1:0];
                cy_d[k]                 = seg_s[k][SEG];
                rem_a_d[k]              = src_a_s[k] >> SEG;
                rem_b_d[k]              = src_b_s[k] >> SEG;
            end else begin
                sum_d[k]   = sum_q[k];
                cy_d[k]    = cy_q[k];
                rem_a_d[k] = rem_a_q[k];
                rem_b_d[k] = rem_b_q[k];
            end
        end
    end

    // Stage registers; reset discards everything in flight.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            v_q <= {STAGES{1'b0}};
            for (int k = 0; k < STAGES; k++) begin
                sum_q[k]   <= {WIDTH{1'b0}};
                cy_q[k]    <= 1'b0;
                rem_a_q[k] <= {WIDTH{1'b0}};
                rem_b_q[k] <= {WIDTH{1'b0}};
            end
        end else begin
            v_q <= v_d;
            for (int k = 0; k < STAGES; k++) begin
                sum_q[k]   <= sum_d[k];
                cy_q[k]    <= cy_d[k];
                rem_a_q[k] <= rem_a_d[k];
                rem_b_q[k] <= rem_b_d[k];
            end
        end
    end

    assign out_valid = v_q[STAGES-1];
    assign out_sum   = sum_q[STAGES-1];
    assign out_cout  = cy_q[STAGES-1];

`ifdef PSA_OVF_EN
    logic sa_q     [STAGES];
    logic sa_d     [STAGES];
    logic sb_q     [STAGES];
    logic sb_d     [STAGES];
    logic src_sa_s [STAGES];
    logic src_sb_s [STAGES];
    logic ovf_q;
    logic ovf_d;

    // Operand sign bits ride along so overflow can be judged once the top sum bit exists.
    always_comb begin
        src_sa_s[0] = in_a[WIDTH-1];
        src_sb_s[0] = in_b[WIDTH-1];
        for (int k = 1; k < STAGES; k++) begin
            src_sa_s[k] = sa_q[k-1];
            src_sb_s[k] = sb_q[k-1];
        end
        for (int k = 0; k < STAGES; k++) begin
            if (load_s[k]) begin
                sa_d[k] = src_sa_s[k];
                sb_d[k] = src_sb_s[k];
            end else begin
                sa_d[k] = sa_q[k];
                sb_d[k] = sb_q[k];
            end
        end
        if (load_s[STAGES-1]) begin
            ovf_d = (src_sa_s[STAGES-1] == src_sb_s[STAGES-1]) &&
                    (sum_d[STAGES-1][WIDTH-1] != src_sa_s[STAGES-1]);
        end else begin
            ovf_d = ovf_q;
        end
    end

    // Sign-bit and overflow registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ovf_q <= 1'b0;
            for (int k = 0; k < STAGES; k++) begin
                sa_q[k] <= 1'b0;
                sb_q[k] <= 1'b0;
            end
        end else begin
            ovf_q <= ovf_d;
            for (int k = 0; k < STAGES; k++) begin
                sa_q[k] <= sa_d[k];
                sb_q[k] <= sb_d[k];
            end
        end
    end

    assign out_ovf = ovf_q;
`else
    assign out_ovf = 1'b0;
`endif

endmodule

// File: tb/tb_pipelined_segment_adder.sv
// Directed self-checking bench for pipelined_segment_adder (latency, carries, streaming, stall, reset).
module tb_pipelined_segment_adder;

    localparam int WIDTH  = 16;
    localparam int SEG    = 4;
    localparam int STAGES = WIDTH / SEG;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [15:0] in_a = 16'h0000;
    logic [15:0] in_b = 16'h0000;
    logic        in_cin = 1'b0;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [15:0] out_sum;
    logic        out_cout;
    logic        out_ovf;

    int pass_cnt = 0;
    int total_cnt = 0;
    int out_cnt = 0;
    int cyc = 0;
    int last_out_cyc = 0;
    int gaps = 0;
    logic had_out = 1'b0;
    logic last_fi = 1'b0;
    logic [16:0] nxt_exp = 17'h00000;
    logic [16:0] exp_q [$];

    logic [15:0] t3a [8] = '{16'h1234, 16'h8000, 16'hAAAA, 16'h00FF, 16'hF0F0, 16'hFFFF, 16'h1111, 16'h7FFF};
    logic [15:0] t3b [8] = '{16'h4321, 16'h8000, 16'h5555, 16'h0001, 16'h0F0F, 16'hFFFF, 16'h2222, 16'h0001};
    logic        t3c [8] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0};
    logic [16:0] t3e [8] = '{17'h05555, 17'h10000, 17'h10000, 17'h00100, 17'h0FFFF, 17'h1FFFF, 17'h03334, 17'h08000};

    logic [15:0] t4a [6] = '{16'h0001, 16'h0010, 16'h0100, 16'h1000, 16'hFFF0, 16'h00FF};
    logic [15:0] t4b [6] = '{16'h0002, 16'h0020, 16'h0200, 16'h2000, 16'h0010, 16'hFF00};
    logic        t4c [6] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1};
    logic [16:0] t4e [6] = '{17'h00003, 17'h00030, 17'h00301, 17'h03000, 17'h10000, 17'h10000};

    always #5 clk = ~clk;

    pipelined_segment_adder #(.WIDTH(WIDTH), .SEG(SEG)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_a      (in_a),
        .in_b      (in_b),
        .in_cin    (in_cin),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_sum   (out_sum),
        .out_cout  (out_cout),
        .out_ovf   (out_ovf)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        total_cnt++;
        assert (obs === expv) pass_cnt++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
    endtask

    // One clock: sample handshakes mid-cycle, score outputs, then step past the rising edge.
    task automatic tick();
        logic fi;
        logic fo;
        logic [16:0] e;
        #1;
        fi = in_valid && in_ready;
        fo = out_valid && out_ready;
        if (fo) begin
            if (exp_q.size() == 0) begin
                check("spurious_out", 32'd1, 32'd0);
            end else begin
                e = exp_q.pop_front();
                check("stream_sum", 32'({out_cout, out_sum}), 32'(e));
            end
`ifndef PSA_OVF_EN
            check("ovf_tied", 32'(out_ovf), 32'd0);
`endif
            if (had_out && cyc != last_out_cyc + 1) gaps++;
            had_out = 1'b1;
            last_out_cyc = cyc;
            out_cnt++;
        end
        if (fi) exp_q.push_back(nxt_exp);
        last_fi = fi;
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic one_op(input string tag, input logic [15:0] a, input logic [15:0] b,
                          input logic c, input logic [16:0] e, input logic eo);
        int n;
        in_a = a;
        in_b = b;
        in_cin = c;
        nxt_exp = e;
        in_valid = 1'b1;
        tick();
        check({tag, "_acc"}, 32'(last_fi), 32'd1);
        in_valid = 1'b0;
        n = 0;
        while (!out_valid && n < 20) begin
            tick();
            n++;
        end
        check({tag, "_lat"}, 32'(n + 1), 32'(STAGES));
        check({tag, "_sum"}, 32'({out_cout, out_sum}), 32'(e));
        check({tag, "_ovf"}, 32'(out_ovf), 32'(eo));
        tick();
    endtask

    initial begin
        int n0;
        int guard;
        int idx;

        // Reset state
        #2;
        check("rst_valid", 32'(out_valid), 32'd0);
        check("rst_sum", 32'(out_sum), 32'd0);
        check("rst_cout", 32'(out_cout), 32'd0);
        check("rst_ovf", 32'(out_ovf), 32'd0);
        @(posedge clk);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        #1;
        check("rst_in_ready", 32'(in_ready), 32'd1);
        out_ready = 1'b1;

        // Full wrap and cross-segment carries
        one_op("t1", 16'hFFFF, 16'h0001, 1'b0, 17'h10000, 1'b0);
        one_op("t2a", 16'h000F, 16'h0001, 1'b0, 17'h00010, 1'b0);
        one_op("t2b", 16'h0FFF, 16'h0000, 1'b1, 17'h01000, 1'b0);

        // Back-to-back stream
        had_out = 1'b0;
        gaps = 0;
        n0 = out_cnt;
        for (int i = 0; i < 8; i++) begin
            in_a = t3a[i];
            in_b = t3b[i];
            in_cin = t3c[i];
            nxt_exp = t3e[i];
            in_valid = 1'b1;
            tick();
            check("t3_acc", 32'(last_fi), 32'd1);
        end
        in_valid = 1'b0;
        guard = 0;
        while (exp_q.size() != 0 && guard < 50) begin
            tick();
            guard++;
        end
        check("t3_count", 32'(out_cnt - n0), 32'd8);
        check("t3_gaps", 32'(gaps), 32'd0);

        // Backpressure for 6 cycles while streaming
        out_ready = 1'b0;
        n0 = out_cnt;
        idx = 0;
        for (int c = 0; c < 6; c++) begin
            in_a = t4a[idx];
            in_b = t4b[idx];
            in_cin = t4c[idx];
            nxt_exp = t4e[idx];
            in_valid = 1'b1;
            tick();
            if (last_fi) idx++;
            if (c >= STAGES - 1) begin
                check("t4_hold_valid", 32'(out_valid), 32'd1);
                check("t4_hold_sum", 32'({out_cout, out_sum}), 32'(t4e[0]));
            end
        end
        check("t4_accepts", 32'(idx), 32'(STAGES));
        check("t4_in_ready_low", 32'(in_ready), 32'd0);
        out_ready = 1'b1;
        guard = 0;
        while (idx < 6 && guard < 50) begin
            in_a = t4a[idx];
            in_b = t4b[idx];
            in_cin = t4c[idx];
            nxt_exp = t4e[idx];
            in_valid = 1'b1;
            tick();
            if (last_fi) idx++;
            guard++;
        end
        in_valid = 1'b0;
        guard = 0;
        while (exp_q.size() != 0 && guard < 50) begin
            tick();
            guard++;
        end
        check("t4_count", 32'(out_cnt - n0), 32'd6);

        // Reset with three results in flight
        out_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            in_a = t3a[i];
            in_b = t3b[i];
            in_cin = t3c[i];
            nxt_exp = t3e[i];
            in_valid = 1'b1;
            tick();
        end
        in_valid = 1'b0;
        tick();
        check("t5_pre_valid", 32'(out_valid), 32'd1);
        rst_n = 1'b0;
        #1;
        check("t5_rst_valid", 32'(out_valid), 32'd0);
        check("t5_rst_sum", 32'(out_sum), 32'd0);
        exp_q.delete();
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        out_ready = 1'b1;
        n0 = out_cnt;
        repeat (8) tick();
        check("t5_no_output", 32'(out_cnt - n0), 32'd0);
        one_op("t5_after", 16'h0001, 16'h0001, 1'b0, 17'h00002, 1'b0);

`ifdef PSA_OVF_EN
        // Signed overflow
        one_op("t6a", 16'h7FFF, 16'h0001, 1'b0, 17'h08000, 1'b1);
        one_op("t6b", 16'h8000, 16'hFFFF, 1'b0, 17'h17FFF, 1'b1);
        one_op("t6c", 16'h1234, 16'h0001, 1'b0, 17'h01235, 1'b0);
`endif

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
